// File: rtl/pipeline_pkg.sv
// Shared RV32IM pipeline types for the register-file writeback path.
package pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned REG_COUNT = 32;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // One-hot register select used by the pending-write scoreboard.
  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [ADDR_W-1:0] rd);
    return REG_COUNT'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding M-unit results until the write port is free.
module wb_result_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Status flags and guarded push/pop qualifiers.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Payload storage; contents are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Single write-port arbiter: ALU stream has priority, M-unit results queue
// behind it, and a scoreboard tracks outstanding mul/div destinations.
module regfile_writeback_arbiter
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   md_issue,
  input  logic [ADDR_W-1:0]      md_issue_rd,
  input  logic                   md_valid,
  output logic                   md_ready,
  input  logic [ADDR_W-1:0]      md_rd,
  input  logic [XLEN-1:0]        md_data,
  output logic                   reg_write_en,
  output logic [ADDR_W-1:0]      reg_write,
  output logic [XLEN-1:0]        write_data,
  output logic [REG_COUNT-1:0]   busy_mask,
  output logic [$clog2(DEPTH):0] md_pending
);

  logic                 alu_win;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  wb_req_t              push_req;
  wb_req_t              fifo_head;
  logic                 wr_en_d;
  logic [ADDR_W-1:0]    wr_rd_d;
  logic [XLEN-1:0]      wr_data_d;
  logic [REG_COUNT-1:0] busy_d;

  // Accept depends only on registered occupancy, so a full FIFO never pops through.
  assign md_ready = !fifo_full;

  // M-unit result payload as presented to the FIFO.
  always_comb begin
    push_req      = '0;
    push_req.rd   = md_rd;
    push_req.data = md_data;
  end

  // Per-cycle arbitration, FIFO control and scoreboard next state.
  always_comb begin
    alu_win   = alu_valid && (alu_rd != '0);
    fifo_pop  = !alu_win && !fifo_empty;
    fifo_push = md_valid && md_ready && (md_rd != '0);

    wr_en_d   = alu_win || fifo_pop;
    wr_rd_d   = reg_write;
    wr_data_d = write_data;
    if (alu_win) begin
      wr_rd_d   = alu_rd;
      wr_data_d = alu_data;
    end else if (fifo_pop) begin
      wr_rd_d   = fifo_head.rd;
      wr_data_d = fifo_head.data;
    end

    // Clear on commit first so a same-cycle re-issue of the same rd keeps the bit set.
    busy_d = busy_mask;
    if (fifo_pop) begin
      busy_d = busy_d & ~rd_onehot(fifo_head.rd);
    end
    if (md_issue && (md_issue_rd != '0)) begin
      busy_d = busy_d | rd_onehot(md_issue_rd);
    end
    busy_d[0] = 1'b0;
  end

  // Registered write port and scoreboard; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_en <= 1'b0;
      reg_write    <= '0;
      write_data   <= '0;
      busy_mask    <= '0;
    end else begin
      reg_write_en <= wr_en_d;
      if (wr_en_d) begin
        reg_write  <= wr_rd_d;
        write_data <= wr_data_d;
      end
      busy_mask <= busy_d;
    end
  end

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (push_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (md_pending),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed table, random
// traffic against a reference model, and a mid-operation reset sequence.
module tb_regfile_writeback_arbiter;
  import pipeline_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        reg_write_en;
  logic [4:0]  reg_write;
  logic [31:0] write_data;
  logic [31:0] busy_mask;
  logic [1:0]  md_pending;

  int errors = 0;
  int checks = 0;

  wb_req_t     mq[$];
  wb_req_t     exp_q[$];
  logic [31:0] m_busy;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        iv;
    logic [4:0]  ir;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [31:0] eb;
    logic [1:0]  ep;
  } vec_t;

  vec_t tbl[23];

  regfile_writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .md_issue     (md_issue),
    .md_issue_rd  (md_issue_rd),
    .md_valid     (md_valid),
    .md_ready     (md_ready),
    .md_rd        (md_rd),
    .md_data      (md_data),
    .reg_write_en (reg_write_en),
    .reg_write    (reg_write),
    .write_data   (write_data),
    .busy_mask    (busy_mask),
    .md_pending   (md_pending)
  );

  always #5 clk = ~clk;

  // Decode must never send an ALU write to a register with a mul/div outstanding.
  always @(posedge clk) begin
    if (rst && alu_valid && alu_rd != 5'd0) begin
      assert (!busy_mask[alu_rd])
        else $error("FAIL alu_write_to_busy rd=%0d busy_mask=%h", alu_rd, busy_mask);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic iv, input logic [4:0] ir,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic [31:0] eb, input logic [1:0] ep);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.iv = iv; v.ir = ir;
    v.mv = mv; v.mr = mr; v.md = md; v.eb = eb; v.ep = ep;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_busy    = '0;
    last_rd   = '0;
    last_data = '0;
  endtask

  // Drive one cycle, advance the model, then check the registered outputs.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ir,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdd);
    wb_req_t e;
    logic    m_ready;
    alu_valid   = av;
    alu_rd      = ar;
    alu_data    = ad;
    md_issue    = iv;
    md_issue_rd = ir;
    md_valid    = mv;
    md_rd       = mr;
    md_data     = mdd;

    m_ready = (mq.size() < DEPTH);
    check("md_ready", 64'(md_ready), 64'(m_ready));

    if (av && ar != 5'd0) begin
      e.rd = ar; e.data = ad;
      exp_q.push_back(e);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_q.push_back(e);
      m_busy[e.rd] = 1'b0;
    end
    if (iv && ir != 5'd0) m_busy[ir] = 1'b1;
    if (mv && m_ready && mr != 5'd0) begin
      e.rd = mr; e.data = mdd;
      mq.push_back(e);
    end

    @(posedge clk); #1;

    if (reg_write_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_write: got rd=%0d data=%h expected no write at %0t",
                 reg_write, write_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_rd", 64'(reg_write), 64'(e.rd));
        check("write_data", 64'(write_data), 64'(e.data));
        last_rd = e.rd; last_data = e.data;
      end
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: got no strobe expected rd=%0d data=%h at %0t",
                 e.rd, e.data, $time);
        last_rd = e.rd; last_data = e.data;
      end else begin
        check("hold_rd", 64'(reg_write), 64'(last_rd));
        check("hold_data", 64'(write_data), 64'(last_data));
      end
    end
    check("busy_mask", 64'(busy_mask), 64'(m_busy));
    check("md_pending", 64'(md_pending), 64'(mq.size()));
  endtask

  initial begin
    logic        av;
    logic [4:0]  ar;
    logic        iv;
    logic [4:0]  ir;
    logic        mv;
    logic [4:0]  mr;

    //             av ar     ad            iv ir    mv mr     md            eb            ep
    tbl[0]  = mk(1, 5'd1,  32'habcdef01, 0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'd0);
    tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'd0);
    tbl[2]  = mk(0, 5'd0,  32'h0,        1, 5'd5, 0, 5'd0, 32'h0,        32'h20,       2'd0);
    tbl[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 1, 5'd5, 32'h12345678, 32'h20,       2'd1);
    tbl[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'd0);
    tbl[5]  = mk(0, 5'd0,  32'h0,        1, 5'd6, 0, 5'd0, 32'h0,        32'h40,       2'd0);
    tbl[6]  = mk(0, 5'd0,  32'h0,        1, 5'd7, 0, 5'd0, 32'h0,        32'hc0,       2'd0);
    tbl[7]  = mk(1, 5'd10, 32'ha0,       0, 5'd0, 1, 5'd6, 32'hd6,       32'hc0,       2'd1);
    tbl[8]  = mk(1, 5'd11, 32'ha1,       0, 5'd0, 1, 5'd7, 32'hd7,       32'hc0,       2'd2);
    tbl[9]  = mk(1, 5'd12, 32'ha2,       0, 5'd0, 1, 5'd8, 32'hd8,       32'hc0,       2'd2);
    tbl[10] = mk(1, 5'd13, 32'ha3,       0, 5'd0, 0, 5'd0, 32'h0,        32'hc0,       2'd2);
    tbl[11] = mk(0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h80,       2'd1);
    tbl[12] = mk(0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'd0);
    tbl[13] = mk(0, 5'd0,  32'h0,        1, 5'd9, 0, 5'd0, 32'h0,        32'h200,      2'd0);
    tbl[14] = mk(0, 5'd0,  32'h0,        0, 5'd0, 1, 5'd9, 32'hd9,       32'h200,      2'd1);
    tbl[15] = mk(1, 5'd0,  32'hffffffff, 0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'd0);
    tbl[16] = mk(0, 5'd0,  32'h0,        0, 5'd0, 1, 5'd0, 32'h55,       32'h0,        2'd0);
    tbl[17] = mk(0, 5'd0,  32'h0,        1, 5'd3, 0, 5'd0, 32'h0,        32'h8,        2'd0);
    tbl[18] = mk(0, 5'd0,  32'h0,        0, 5'd0, 1, 5'd3, 32'hd3,       32'h8,        2'd1);
    tbl[19] = mk(0, 5'd0,  32'h0,        1, 5'd3, 0, 5'd0, 32'h0,        32'h8,        2'd0);
    tbl[20] = mk(0, 5'd0,  32'h0,        1, 5'd0, 0, 5'd0, 32'h0,        32'h8,        2'd0);
    tbl[21] = mk(0, 5'd0,  32'h0,        0, 5'd0, 1, 5'd3, 32'h33,       32'h8,        2'd1);
    tbl[22] = mk(0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd0, 32'h0,        32'h0,        2'd0);

    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    md_issue = 0; md_issue_rd = 0; md_valid = 0; md_rd = 0; md_data = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_write_en", 64'(reg_write_en), 64'(0));
    check("rst_write_rd", 64'(reg_write), 64'(0));
    check("rst_write_data", 64'(write_data), 64'(0));
    check("rst_busy", 64'(busy_mask), 64'(0));
    check("rst_pending", 64'(md_pending), 64'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rel_md_ready", 64'(md_ready), 64'(1));

    // Directed sequence with hand-derived scoreboard/occupancy values.
    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].iv, tbl[i].ir,
            tbl[i].mv, tbl[i].mr, tbl[i].md);
      check($sformatf("tbl%0d_busy", i), 64'(busy_mask), 64'(tbl[i].eb));
      check($sformatf("tbl%0d_pending", i), 64'(md_pending), 64'(tbl[i].ep));
    end

    // Random legal traffic: ALU never targets a busy register.
    for (int n = 0; n < 300; n++) begin
      av = 1'($urandom_range(0, 1));
      ar = 5'($urandom_range(0, 31));
      if (m_busy[ar]) ar = 5'd0;
      iv = ($urandom_range(0, 3) == 0);
      ir = 5'($urandom_range(0, 31));
      mv = 1'($urandom_range(0, 1));
      mr = 5'($urandom_range(0, 31));
      cycle(av, ar, $urandom, iv, ir, mv, mr, $urandom);
    end
    repeat (4) cycle(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0);

    // Fill the FIFO behind ALU traffic, then reset mid-flight.
    cycle(0, 5'd0,  32'h0,  1, 5'd14, 0, 5'd0,  32'h0);
    cycle(0, 5'd0,  32'h0,  1, 5'd15, 0, 5'd0,  32'h0);
    cycle(1, 5'd1,  32'h11, 0, 5'd0,  1, 5'd14, 32'he);
    cycle(1, 5'd2,  32'h22, 0, 5'd0,  1, 5'd15, 32'hf);
    check("pre_rst_pending", 64'(md_pending), 64'(2));
    check("pre_rst_write_en", 64'(reg_write_en), 64'(1));

    #2;
    rst = 1'b0;
    alu_valid = 0; md_issue = 0; md_valid = 0;
    alu_rd = 0; md_issue_rd = 0; md_rd = 0;
    #1;
    check("midrst_write_en", 64'(reg_write_en), 64'(0));
    check("midrst_busy", 64'(busy_mask), 64'(0));
    check("midrst_pending", 64'(md_pending), 64'(0));
    model_reset();
    @(posedge clk); #1;
    check("midrst_hold_en", 64'(reg_write_en), 64'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_md_ready", 64'(md_ready), 64'(1));
    check("post_rst_write_en", 64'(reg_write_en), 64'(0));
    cycle(1, 5'd4, 32'h44, 0, 5'd0, 0, 5'd0, 32'h0);
    cycle(0, 5'd0, 32'h0,  0, 5'd0, 0, 5'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
